// File: rtl/tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_pkg: shared widths, default packet geometry and sequencer state type. Rev 1.0
// ----------------------------------------------------------------------------
package tx_pkg;

   localparam int HDR_IDX_W              = 6;
   localparam int BRAM_ADDR_W            = 13;
   localparam int SEGMENT_NUMBER_MAX_DEF = 150;
   localparam int HEADER_LEN_DEF         = 42;
   localparam int PAYLOAD_LEN_DEF        = 1280;
   localparam int GAP_LEN_DEF            = 20;
   localparam int READ_LEAD_DEF          = 3;
   localparam int STATE_W                = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_HEADER   = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_GAP      = 3'd4
   } tx_state_e;

   typedef logic [BRAM_ADDR_W-1:0] addr_t;
   typedef logic [BRAM_ADDR_W:0]   addr_ext_t;

   // Zero means "one", anything above the ceiling is clamped to it.
   function automatic logic [15:0] eff_count(input logic [15:0] value, input logic [15:0] max_value);
      logic [15:0] r;
      r = value;
      if (value == 16'd0) r = 16'd1;
      else if (value > max_value) r = max_value;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_packet_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_packet_sequencer_if: frame request, MAC handshake and packet strobes. Rev 1.0
// ----------------------------------------------------------------------------
interface tx_packet_sequencer_if;
   import tx_pkg::*;

   logic                   frame_start;
   logic [7:0]             redundancy;
   logic [15:0]            segment_count;
   logic                   mac_ready;
   logic                   busy;
   logic                   pkt_start;
   logic                   hdr_valid;
   logic [HDR_IDX_W-1:0]   hdr_idx;
   logic [7:0]             txid;
   logic [15:0]            segment_num;
   logic [BRAM_ADDR_W-1:0] count_for_bram;
   logic                   count_for_bram_en;
   logic [BRAM_ADDR_W-1:0] count_for_bram_b;
   logic                   data_user;
   logic                   frame_done;

   modport master (
      input  frame_start, redundancy, segment_count, mac_ready,
      output busy, pkt_start, hdr_valid, hdr_idx, txid, segment_num,
             count_for_bram, count_for_bram_en, count_for_bram_b, data_user, frame_done
   );

   modport slave (
      output frame_start, redundancy, segment_count, mac_ready,
      input  busy, pkt_start, hdr_valid, hdr_idx, txid, segment_num,
             count_for_bram, count_for_bram_en, count_for_bram_b, data_user, frame_done
   );

endinterface
`default_nettype wire

// File: rtl/tx_loop_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_loop_counter: txid (outer) / segment (inner) nested packet loop. Rev 1.0
// ----------------------------------------------------------------------------
module tx_loop_counter
   import tx_pkg::*;
#(
   parameter int SEGMENT_NUMBER_MAX = SEGMENT_NUMBER_MAX_DEF
) (
   input  logic        clk125MHz,
   input  logic        rstn,
   input  logic        load,
   input  logic [7:0]  redundancy,
   input  logic [15:0] segment_count,
   input  logic        advance,
   output logic [7:0]  txid,
   output logic [15:0] segment_num,
   output logic        last
);

   localparam logic [15:0] c_seg_max = 16'(SEGMENT_NUMBER_MAX);

   logic [7:0]  txid_q, txid_d;
   logic [7:0]  red_eff_q, red_eff_d;
   logic [15:0] seg_q, seg_d;
   logic [15:0] seg_last_q, seg_last_d;

   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn) begin
         txid_q     <= '0;
         red_eff_q  <= '0;
         seg_q      <= '0;
         seg_last_q <= '0;
      end else begin
         txid_q     <= txid_d;
         red_eff_q  <= red_eff_d;
         seg_q      <= seg_d;
         seg_last_q <= seg_last_d;
      end
   end

   always_comb begin
      txid_d     = txid_q;
      red_eff_d  = red_eff_q;
      seg_d      = seg_q;
      seg_last_d = seg_last_q;
      last       = (txid_q == red_eff_q) && (seg_q == seg_last_q);
      if (load) begin
         red_eff_d  = (redundancy == 8'd0) ? 8'd1 : redundancy;
         seg_last_d = eff_count(segment_count, c_seg_max) - 16'd1;
         txid_d     = 8'd1;
         seg_d      = 16'd0;
      end else if (advance && !last) begin
         // Segment is the inner loop: wrap it and step the copy index.
         if (seg_q == seg_last_q) begin
            seg_d  = 16'd0;
            txid_d = txid_q + 8'd1;
         end else begin
            seg_d  = seg_q + 16'd1;
         end
      end
   end

   assign txid        = txid_q;
   assign segment_num = seg_q;

endmodule
`default_nettype wire

// File: rtl/tx_packet_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_packet_sequencer: per-frame packet walk, header/payload/gap timing. Rev 1.0
// ----------------------------------------------------------------------------
module tx_packet_sequencer
   import tx_pkg::*;
#(
   parameter int SEGMENT_NUMBER_MAX = SEGMENT_NUMBER_MAX_DEF,
   parameter int HEADER_LEN         = HEADER_LEN_DEF,
   parameter int PAYLOAD_LEN        = PAYLOAD_LEN_DEF,
   parameter int GAP_LEN            = GAP_LEN_DEF,
   parameter int READ_LEAD          = READ_LEAD_DEF
) (
   input  logic                  clk125MHz,
   input  logic                  rstn,
   tx_packet_sequencer_if.master bus
);

   localparam addr_t     c_hdr_last     = addr_t'(HEADER_LEN - 1);
   localparam addr_t     c_pay_last     = addr_t'(PAYLOAD_LEN - 1);
   localparam addr_t     c_gap_last     = addr_t'(GAP_LEN - 1);
   localparam addr_t     c_rd_start     = addr_t'(HEADER_LEN - READ_LEAD);
   localparam addr_ext_t c_lead         = addr_ext_t'(READ_LEAD);
   localparam addr_ext_t c_pay_last_ext = addr_ext_t'(PAYLOAD_LEN - 1);

   tx_state_e   state_q, state_d;
   addr_t       cnt_q, cnt_d;
   logic        frame_done_q, frame_done_d;
   logic        frame_accept;
   logic        loop_advance;
   logic        loop_last;
   logic        in_header;
   logic        in_payload;
   logic [7:0]  txid;
   logic [15:0] segment_num;
   addr_ext_t   lead_raw;

   tx_loop_counter #(
      .SEGMENT_NUMBER_MAX(SEGMENT_NUMBER_MAX)
   ) u_loop (
      .clk125MHz     (clk125MHz),
      .rstn          (rstn),
      .load          (frame_accept),
      .redundancy    (bus.redundancy),
      .segment_count (bus.segment_count),
      .advance       (loop_advance),
      .txid          (txid),
      .segment_num   (segment_num),
      .last          (loop_last)
   );

   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // One shared phase counter; it restarts at 0 on every phase change.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      frame_accept = 1'b0;
      loop_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A request coincident with frame_done belongs to the old frame.
            if (bus.frame_start && !frame_done_q) begin
               frame_accept = 1'b1;
               state_d      = ST_WAIT_RDY;
               cnt_d        = '0;
            end
         end
         ST_WAIT_RDY: begin
            if (bus.mac_ready) begin
               state_d = ST_HEADER;
               cnt_d   = '0;
            end
         end
         ST_HEADER: begin
            if (cnt_q == c_hdr_last) begin
               state_d = ST_PAYLOAD;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + addr_t'(1);
            end
         end
         ST_PAYLOAD: begin
            if (cnt_q == c_pay_last) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + addr_t'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == c_gap_last) begin
               loop_advance = 1'b1;
               cnt_d        = '0;
               if (loop_last) begin
                  state_d      = ST_IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d      = ST_WAIT_RDY;
               end
            end else begin
               cnt_d = cnt_q + addr_t'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read address runs READ_LEAD ahead of the write index, saturating at the last byte.
   always_comb begin
      lead_raw = '0;
      if (in_header && (cnt_q >= c_rd_start)) lead_raw = {1'b0, cnt_q} - {1'b0, c_rd_start};
      else if (in_payload)                     lead_raw = {1'b0, cnt_q} + c_lead;
   end

   assign in_header  = (state_q == ST_HEADER);
   assign in_payload = (state_q == ST_PAYLOAD);

   assign bus.busy              = (state_q != ST_IDLE);
   assign bus.pkt_start         = in_header && (cnt_q == '0);
   assign bus.hdr_valid         = in_header;
   assign bus.hdr_idx           = in_header ? cnt_q[HDR_IDX_W-1:0] : '0;
   assign bus.txid              = txid;
   assign bus.segment_num       = segment_num;
   assign bus.count_for_bram    = in_payload ? cnt_q : '0;
   assign bus.count_for_bram_en = in_payload;
   assign bus.count_for_bram_b  = (lead_raw > c_pay_last_ext) ? c_pay_last : lead_raw[BRAM_ADDR_W-1:0];
   assign bus.data_user         = in_payload;
   assign bus.frame_done        = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tx_packet_sequencer: directed frames against hand-computed timing/order. Rev 1.0
// ----------------------------------------------------------------------------
module tb_tx_packet_sequencer;
   import tx_pkg::*;

   logic clk = 1'b0;
   logic rstn_a;
   logic rstn_b;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   tx_packet_sequencer_if ifa();
   tx_packet_sequencer_if ifb();

   tx_packet_sequencer u_dut_a (
      .clk125MHz (clk),
      .rstn      (rstn_a),
      .bus       (ifa)
   );

   // Short-packet instance so a clamped 150-packet frame stays cheap to run.
   tx_packet_sequencer #(
      .PAYLOAD_LEN (8),
      .GAP_LEN     (4)
   ) u_dut_b (
      .clk125MHz (clk),
      .rstn      (rstn_b),
      .bus       (ifb)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] lead_exp(input logic [12:0] c);
      int t;
      t = int'(c) + 3;
      return (t > 1279) ? 13'd1279 : 13'(t);
   endfunction

   function automatic logic [63:0] outs_a();
      return {2'b00, ifa.busy, ifa.pkt_start, ifa.hdr_valid, ifa.hdr_idx, ifa.txid,
              ifa.segment_num, ifa.count_for_bram, ifa.count_for_bram_en,
              ifa.count_for_bram_b, ifa.data_user, ifa.frame_done};
   endfunction

   // ---------------- observation of instance A ----------------
   int          pkts_a = 0, done_a = 0, pkt_cyc_a = 0, done_cyc_a = 0;
   int          du_len_a = 0, hold_a = 0, stab_err_a = 0, lead_err_a = 0;
   logic        du_prev_a = 1'b0, busy_at_done_a = 1'b1;
   logic [12:0] b_hdr39_a = 13'h1fff, b_cfb0_a = 13'h1fff;
   logic [7:0]  tx_s_a = '0;
   logic [15:0] seg_s_a = '0;
   int          du_lens_a[$];
   int          holds_a[$];
   logic [23:0] order_a[$];

   always @(negedge clk) begin
      if (!rstn_a) begin
         du_len_a  <= 0;
         du_prev_a <= 1'b0;
      end else begin
         if (ifa.pkt_start) begin
            pkts_a    <= pkts_a + 1;
            pkt_cyc_a <= cyc;
            order_a.push_back({ifa.txid, ifa.segment_num});
         end
         if (ifa.hdr_valid && ifa.hdr_idx == 6'd39) b_hdr39_a <= ifa.count_for_bram_b;
         if (ifa.data_user) begin
            du_len_a <= du_len_a + 1;
            if (ifa.count_for_bram == 13'd0) b_cfb0_a <= ifa.count_for_bram_b;
            if (ifa.count_for_bram_b != lead_exp(ifa.count_for_bram)) lead_err_a <= lead_err_a + 1;
            if (!du_prev_a) begin
               tx_s_a  <= ifa.txid;
               seg_s_a <= ifa.segment_num;
               hold_a  <= (ifa.count_for_bram_b == 13'd1279) ? 1 : 0;
            end else begin
               if (ifa.txid != tx_s_a || ifa.segment_num != seg_s_a) stab_err_a <= stab_err_a + 1;
               if (ifa.count_for_bram_b == 13'd1279) hold_a <= hold_a + 1;
            end
         end else if (du_prev_a) begin
            du_lens_a.push_back(du_len_a);
            holds_a.push_back(hold_a);
            du_len_a <= 0;
         end
         du_prev_a <= ifa.data_user;
         if (ifa.frame_done) begin
            done_a         <= done_a + 1;
            done_cyc_a     <= cyc;
            busy_at_done_a <= ifa.busy;
         end
      end
   end

   // ---------------- observation of instance B ----------------
   int          pkts_b = 0, done_b = 0;
   logic [23:0] last_b = '0;

   always @(negedge clk) begin
      if (rstn_b) begin
         if (ifb.pkt_start) begin
            pkts_b <= pkts_b + 1;
            last_b <= {ifb.txid, ifb.segment_num};
         end
         if (ifb.frame_done) done_b <= done_b + 1;
      end
   end

   int fs_cyc = 0;

   task automatic start_frame_a(input logic [7:0] red, input logic [15:0] seg);
      ifa.redundancy    = red;
      ifa.segment_count = seg;
      ifa.frame_start   = 1'b1;
      fs_cyc            = cyc;
      @(negedge clk);
      ifa.frame_start   = 1'b0;
   endtask

   task automatic wait_done_a(input string tag, input int budget);
      int start;
      int n;
      start = done_a;
      n     = 0;
      while (done_a == start && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, longint'(done_a != start), 1);
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [23:0] order_at(input int idx);
      return (idx < order_a.size()) ? order_a[idx] : 24'hffffff;
   endfunction

   function automatic int last_len();
      return (du_lens_a.size() > 0) ? du_lens_a[$] : -1;
   endfunction

   logic [23:0] t2_exp [6] = '{24'h010000, 24'h010001, 24'h010002,
                               24'h020000, 24'h020001, 24'h020002};

   initial begin
      int   base;
      int   obase;
      int   lbase;
      int   bad;
      int   n;
      logic strobes;

      ifa.frame_start = 1'b0; ifa.redundancy = '0; ifa.segment_count = '0; ifa.mac_ready = 1'b0;
      ifb.frame_start = 1'b0; ifb.redundancy = '0; ifb.segment_count = '0; ifb.mac_ready = 1'b0;
      rstn_a = 1'b0;
      rstn_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", outs_a(), 0);
      rstn_a = 1'b1;
      rstn_b = 1'b1;
      repeat (2) @(negedge clk);

      // Single packet: timing and read-lead landmarks
      ifa.mac_ready = 1'b1;
      start_frame_a(8'd1, 16'd1);
      check("busy_after_start", ifa.busy, 1);
      wait_done_a("t1_done", 2000);
      check("t1_pkt_start_latency", pkt_cyc_a - fs_cyc, 2);
      check("t1_frame_done_latency", done_cyc_a - pkt_cyc_a, 1342);
      check("t1_packets", pkts_a, 1);
      check("t1_data_user_len", last_len(), 1280);
      check("t1_rd_at_hdr39", b_hdr39_a, 0);
      check("t1_rd_at_cfb0", b_cfb0_a, 3);
      check("t1_rd_hold_1279", (holds_a.size() > 0) ? holds_a[$] : -1, 4);
      check("t1_busy_at_done", busy_at_done_a, 0);
      check("t1_idle_after", ifa.busy, 0);

      // 2 copies x 3 segments: loop order and stability
      base  = pkts_a;
      obase = order_a.size();
      lbase = du_lens_a.size();
      start_frame_a(8'd2, 16'd3);
      wait_done_a("t2_done", 9000);
      check("t2_packets", pkts_a - base, 6);
      for (int i = 0; i < 6; i++) check($sformatf("t2_order%0d", i), order_at(obase + i), t2_exp[i]);
      bad = 0;
      for (int i = lbase; i < du_lens_a.size(); i++) if (du_lens_a[i] != 1280) bad++;
      check("t2_bad_du_lens", bad, 0);
      check("t2_id_stability_err", stab_err_a, 0);
      check("t2_read_lead_err", lead_err_a, 0);

      // MAC back-pressure in WAIT_RDY, then drop mac_ready mid-payload
      ifa.mac_ready = 1'b0;
      start_frame_a(8'd1, 16'd1);
      strobes = 1'b0;
      repeat (50) begin
         @(negedge clk);
         strobes = strobes | ifa.pkt_start | ifa.hdr_valid | ifa.data_user | ifa.count_for_bram_en;
      end
      check("t3_no_strobes_waiting", strobes, 0);
      check("t3_busy_waiting", ifa.busy, 1);
      ifa.mac_ready = 1'b1;
      n = 0;
      while (!ifa.data_user && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (100) @(negedge clk);
      ifa.mac_ready = 1'b0;
      wait_done_a("t3_done", 2000);
      check("t3_data_user_len", last_len(), 1280);
      ifa.mac_ready = 1'b1;

      // frame_start mid-frame and coincident with frame_done are both ignored
      base = pkts_a;
      start_frame_a(8'd1, 16'd2);
      repeat (60) @(negedge clk);
      ifa.redundancy = 8'd3; ifa.segment_count = 16'd5; ifa.frame_start = 1'b1;
      @(negedge clk);
      ifa.frame_start = 1'b0;
      n = 0;
      while (!ifa.frame_done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("t5_frame_done_seen", ifa.frame_done, 1);
      ifa.redundancy = 8'd1; ifa.segment_count = 16'd1; ifa.frame_start = 1'b1;
      @(negedge clk);
      ifa.frame_start = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_packets", pkts_a - base, 2);
      check("t5_busy_after_ignored_start", ifa.busy, 0);

      // Abort in the second copy, then a clean frame
      start_frame_a(8'd2, 16'd1);
      n = 0;
      while (!(ifa.data_user && ifa.txid == 8'd2 && ifa.count_for_bram == 13'd600) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("t6_reached_cfb600", ifa.count_for_bram, 600);
      rstn_a = 1'b0;
      #1;
      check("t6_outputs_in_reset", outs_a(), 0);
      @(negedge clk);
      rstn_a = 1'b1;
      repeat (2) @(negedge clk);
      obase = order_a.size();
      start_frame_a(8'd1, 16'd1);
      wait_done_a("t6_done", 2000);
      check("t6_first_packet_id", order_at(obase), 24'h010000);
      check("t6_data_user_len", last_len(), 1280);

      // redundancy 0 -> 1, segment_count 500 -> 150
      ifb.mac_ready = 1'b1; ifb.redundancy = 8'd0; ifb.segment_count = 16'd500; ifb.frame_start = 1'b1;
      @(negedge clk);
      ifb.frame_start = 1'b0;
      n = 0;
      while (done_b == 0 && n < 9000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("t7_frame_done", done_b, 1);
      check("t7_packets", pkts_b, 150);
      check("t7_last_packet_id", last_b, 24'h010095);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
